util_heartbeat_gen: RTL and testbench
=====================================

# util_heartbeat_gen

Programmable heartbeat transmitter that drives the `monitor_in` of a `util_watch_dog` or any external supervisor. It emits one beat every `period` ticks of a shared `cnt_pulse` time base, either as a pulse of `width` ticks or as a level toggle. A `hold` input freezes beat generation so benches and system fault-injection logic can force a watchdog timeout.

## Interface

Parameters:
- `CNT_WIDTH`, 32, width of `period`, `width` and the internal tick counters.
- `BEAT_CNT_WIDTH`, 16, width of the `beat_cnt` status counter.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable, level-sensitive.
- `mode`  in  1  0 = pulse mode, 1 = toggle mode.
- `period`  in  CNT_WIDTH  ticks between beat starts.
- `width`  in  CNT_WIDTH  pulse-mode high time, in ticks.
- `cnt_pulse`  in  1  tick enable; counters advance only in cycles where it is 1.
- `hold`  in  1  freezes the generator while 1.
- `beat_out`  out  1  heartbeat line to the supervisor.
- `beat_strobe`  out  1  one-cycle strobe in the cycle each beat starts.
- `busy`  out  1  1 while the generator is running (not IDLE).
- `beat_cnt`  out  BEAT_CNT_WIDTH  number of beats emitted since start; wraps.

## Operation

- **States:** IDLE, HIGH, LOW.
- **Reset:** the state goes to IDLE; `beat_out`, `beat_strobe`, `busy` and `beat_cnt` are all 0; both counters are cleared.
- **Start (IDLE → HIGH):** when `en`=1 and `hold`=0 in IDLE, the next edge starts beat 1.
- **Every beat start:**
  - the period counter clears to 0;
  - `beat_strobe` = 1 for that single cycle;
  - `beat_cnt` increments;
  - `period` and `width` are latched as `period_l` and `width_l`. Mid-beat changes to these inputs take effect at the next beat.
  - On start from IDLE, `beat_cnt` loads 1 rather than incrementing.
- **Clamping at latch time:**
  - `period_l` = max(`period`, 2).
  - `width_l` = min(max(`width`, 1), `period_l` − 1).
  - Result: a pulse-mode output never sticks high or low.
- **Pulse mode:**
  - `beat_out` = 1 in HIGH and 0 in LOW.
  - HIGH → LOW once `width_l` ticks have elapsed since the beat start.
  - LOW → new beat (state HIGH) once `period_l` ticks have elapsed since the beat start.
- **Toggle mode:**
  - `beat_out` inverts at each beat start; `width` is ignored.
  - The FSM stays in HIGH and re-beats every `period_l` ticks.
- **Tick rule:** a tick is a cycle with `cnt_pulse`=1, `hold`=0 and the FSM not in IDLE. The period counter increments on ticks only.
- **Hold:** while `hold`=1, the counters freeze, `beat_out` keeps its value, and no strobes or transitions occur. Releasing `hold` resumes exactly where the generator stopped.
- **Disable:** `en`=0 in any non-IDLE state returns to IDLE at the next edge and clears `beat_out`. `beat_cnt` keeps its value until the next start.
- **`mode` changes while running:** take effect at the next beat start. Switching pulse → toggle inverts from the current `beat_out` value.
- **Wrap:** `beat_cnt` wraps from all-ones to 0 without a strobe anomaly.

## Timing

- Start latency: `en` goes 1 in cycle N (with `hold`=0), and the FSM is in IDLE. In cycle N+1, `beat_out`=1 (toggle mode: inverted), `beat_strobe`=1, `busy`=1.
- With `cnt_pulse` tied to 1, beat starts are exactly `period_l` cycles apart. In pulse mode, `beat_out` is high for exactly `width_l` cycles.
- With a sparse `cnt_pulse`, a transition occurs in the cycle after the tick that completes the count.
- Stop latency: `en`=0 in cycle N gives `busy`=0 and `beat_out`=0 in cycle N+1.
- Asynchronous `rst` clears all outputs immediately, including mid-beat. Deassertion is synchronous to `clk` upstream.
- Simultaneous `en` fall and beat start: disable wins. No strobe is issued and `beat_cnt` is unchanged.
- Simultaneous `hold` rise and tick: hold wins and the tick is ignored.

## Test plan

- Pulse mode, `period`=4, `width`=2, `cnt_pulse`=1 → `beat_out` repeats 1,1,0,0. `beat_strobe` fires every 4 cycles; `beat_cnt` = 1,2,3… matching the strobes.
- Clamping, `period`=0, `width`=0 → period 2, width 1, `beat_out` = 1,0,1,0. `period`=5, `width`=9 → high 4, low 1.
- Toggle mode, `period`=3 → `beat_out` inverts every 3 cycles starting from 1. Then `cnt_pulse` asserted 1 cycle in 4 → inversions every 12 cycles.
- `hold` asserted for 10 cycles mid-HIGH (`period`=8, `width`=4) → `beat_out` stays 1 and no strobes. After release the remaining HIGH and LOW durations are unchanged.
- `en` dropped mid-beat, then re-raised → `beat_out`=0 and `busy`=0 one cycle after the drop. On restart, `beat_cnt` reloads 1 one cycle after `en` rises.
- Loopback into `util_watch_dog` (`preset`=0xFF) → no timeout while running with `period`=16. Asserting `hold` beyond the preset produces a watchdog timeout; releasing `hold` clears it.

Source files
------------

// File: rtl/util_heartbeat_gen.sv
// Programmable heartbeat transmitter: emits one beat every period_l ticks of cnt_pulse,
// either as a width_l-tick pulse or as a level toggle, with hold/disable control.
module util_heartbeat_gen #(
    parameter int CNT_WIDTH      = 32,
    parameter int BEAT_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [CNT_WIDTH-1:0]      period,
    input  logic [CNT_WIDTH-1:0]      width,
    input  logic                      cnt_pulse,
    input  logic                      hold,
    output logic                      beat_out,
    output logic                      beat_strobe,
    output logic                      busy,
    output logic [BEAT_CNT_WIDTH-1:0] beat_cnt
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t                    state, state_d;
    logic [CNT_WIDTH-1:0]      pcnt, pcnt_d, pcnt_inc;
    logic [CNT_WIDTH-1:0]      period_l, period_l_d, width_l, width_l_d;
    logic [CNT_WIDTH-1:0]      period_clamp, width_min, width_clamp;
    logic                      mode_l, mode_l_d;
    logic                      beat_out_d, beat_strobe_d;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_d;
    logic                      tick, beat_start, first_beat;

    // Clamp so a pulse always has at least one high and one low tick.
    always_comb begin
        period_clamp = (period < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : period;
        width_min    = (width == '0) ? CNT_WIDTH'(1) : width;
        width_clamp  = (width_min >= period_clamp) ? period_clamp - CNT_WIDTH'(1) : width_min;
    end

    assign tick     = cnt_pulse && !hold && (state != IDLE);
    assign pcnt_inc = pcnt + CNT_WIDTH'(1);
    assign busy     = (state != IDLE);

    always_comb begin
        state_d       = state;
        pcnt_d        = pcnt;
        period_l_d    = period_l;
        width_l_d     = width_l;
        mode_l_d      = mode_l;
        beat_out_d    = beat_out;
        beat_strobe_d = 1'b0;
        beat_cnt_d    = beat_cnt;
        beat_start    = 1'b0;
        first_beat    = 1'b0;

        if (state == IDLE) begin
            if (en && !hold) begin
                beat_start = 1'b1;
                first_beat = 1'b1;
            end
        end else if (!en) begin
            // Disable beats any pending beat start in the same cycle.
            state_d    = IDLE;
            beat_out_d = 1'b0;
        end else if (tick) begin
            pcnt_d = pcnt_inc;
            case (state)
                HIGH: begin
                    if (mode_l) begin
                        if (pcnt_inc >= period_l) beat_start = 1'b1;
                    end else if (pcnt_inc >= width_l) begin
                        state_d    = LOW;
                        beat_out_d = 1'b0;
                    end
                end
                LOW: if (pcnt_inc >= period_l) beat_start = 1'b1;
                default: state_d = IDLE;
            endcase
        end

        if (beat_start) begin
            state_d       = HIGH;
            pcnt_d        = '0;
            beat_strobe_d = 1'b1;
            beat_cnt_d    = first_beat ? BEAT_CNT_WIDTH'(1) : beat_cnt + BEAT_CNT_WIDTH'(1);
            period_l_d    = period_clamp;
            width_l_d     = width_clamp;
            mode_l_d      = mode;
            beat_out_d    = mode ? ~beat_out : 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pcnt        <= '0;
            period_l    <= CNT_WIDTH'(2);
            width_l     <= CNT_WIDTH'(1);
            mode_l      <= 1'b0;
            beat_out    <= 1'b0;
            beat_strobe <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            state       <= state_d;
            pcnt        <= pcnt_d;
            period_l    <= period_l_d;
            width_l     <= width_l_d;
            mode_l      <= mode_l_d;
            beat_out    <= beat_out_d;
            beat_strobe <= beat_strobe_d;
            beat_cnt    <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_util_heartbeat_gen.sv
// Randomized and directed bench for util_heartbeat_gen against a phase-based reference model.
module tb_util_heartbeat_gen;

    localparam int CW  = 32;
    localparam int BCW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0, mode = 1'b0, cnt_pulse = 1'b0, hold = 1'b0;
    logic [CW-1:0]  period = '0, width = '0;
    logic           beat_out, beat_strobe, busy;
    logic [BCW-1:0] beat_cnt;

    int n_chk = 0;
    int n_err = 0;

    // Model: a running flag, ticks elapsed since the current beat began, and latched settings.
    bit          m_run, m_out, m_str, m_ml;
    int unsigned m_phase, m_pl, m_wl, m_cnt;

    util_heartbeat_gen #(.CNT_WIDTH(CW), .BEAT_CNT_WIDTH(BCW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .width(width),
        .cnt_pulse(cnt_pulse), .hold(hold), .beat_out(beat_out), .beat_strobe(beat_strobe),
        .busy(busy), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_out = 0; m_str = 0; m_cnt = 0; m_phase = 0; m_ml = 0;
    endtask

    task automatic m_beat(input bit first, input bit md, input int unsigned p, input int unsigned w);
        m_phase = 0;
        m_str   = 1;
        m_cnt   = first ? 1 : (m_cnt + 1) % (1 << BCW);
        m_pl    = (p < 2) ? 2 : p;
        m_wl    = (w == 0) ? 1 : w;
        if (m_wl > m_pl - 1) m_wl = m_pl - 1;
        m_ml    = md;
        m_out   = md ? !m_out : 1'b1;
    endtask

    task automatic m_step(input bit e, input bit h, input bit cp, input bit md,
                          input int unsigned p, input int unsigned w);
        m_str = 0;
        if (!m_run) begin
            if (e && !h) begin
                m_run = 1;
                m_out = 0;
                m_beat(1, md, p, w);
            end
        end else if (!e) begin
            m_run = 0;
            m_out = 0;
        end else if (!h && cp) begin
            m_phase++;
            if (m_phase == m_pl) m_beat(0, md, p, w);
            else if (!m_ml) m_out = (m_phase < m_wl);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".beat_out"}, 32'(beat_out), 32'(m_out));
        chk({tag, ".strobe"},   32'(beat_strobe), 32'(m_str));
        chk({tag, ".busy"},     32'(busy), 32'(m_run));
        chk({tag, ".beat_cnt"}, 32'(beat_cnt), m_cnt);
    endtask

    // Called at a negedge: drive, clock, update model, check at the next negedge.
    task automatic step(input string tag, input bit e, input bit h, input bit cp, input bit md,
                        input int unsigned p, input int unsigned w);
        en = e; hold = h; cnt_pulse = cp; mode = md; period = CW'(p); width = CW'(w);
        @(posedge clk);
        m_step(e, h, cp, md, p, w);
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        compare_all("reset");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) step("pulse4_2", 1, 0, 1, 0, 4, 2);
        step("stop", 0, 0, 1, 0, 4, 2);
        step("idle", 0, 0, 1, 0, 4, 2);

        for (int i = 0; i < 10; i++) step("clamp0", 1, 0, 1, 0, 0, 0);
        step("stop", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step("clamp5_9", 1, 0, 1, 0, 5, 9);
        step("stop", 0, 0, 1, 0, 5, 9);

        for (int i = 0; i < 12; i++) step("toggle3", 1, 0, 1, 1, 3, 0);
        for (int i = 0; i < 30; i++) step("toggle_sparse", 1, 0, (i % 4) == 3, 1, 3, 0);
        step("stop", 0, 0, 1, 1, 3, 0);

        for (int i = 0; i < 2; i++)  step("hold_pre", 1, 0, 1, 0, 8, 4);
        for (int i = 0; i < 10; i++) step("hold", 1, 1, 1, 0, 8, 4);
        for (int i = 0; i < 20; i++) step("hold_post", 1, 0, 1, 0, 8, 4);
        step("drop", 0, 0, 1, 0, 8, 4);
        for (int i = 0; i < 40; i++) step("wrap", 1, 0, 1, 0, 2, 1);

        // Asynchronous reset mid-beat must clear outputs without a clock edge.
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 1, 0, 6, 3);
        #2 rst = 1'b1;
        #1 m_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 800; i++) begin
            bit e, h, cp, md;
            e  = ($urandom_range(0, 19) != 0);
            h  = ($urandom_range(0, 9) == 0);
            cp = ($urandom_range(0, 1) == 1);
            md = ($urandom_range(0, 15) == 0) ? !mode : mode;
            step("rand", e, h, cp, md, $urandom_range(0, 7), $urandom_range(0, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
